// File: rtl/movavg_pkg.sv
// movavg_pkg -- shared definitions for the moving-average controller.
//   DATA_W      : default sample/result width
//   MODE_*      : cfg_mode encodings (window lengths 1,2,3,4,8,16)
//   state_t     : controller FSM states
//   win_len()   : window length for a mode (0 for rejected encodings)
//   mode_ok()   : 1 when the encoding is an accepted mode
package movavg_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] MODE_W1  = 3'b000;
  localparam logic [2:0] MODE_W2  = 3'b001;
  localparam logic [2:0] MODE_W3  = 3'b010;
  localparam logic [2:0] MODE_W4  = 3'b011;
  localparam logic [2:0] MODE_W8  = 3'b100;
  localparam logic [2:0] MODE_W16 = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_SWITCH = 2'd3
  } state_t;

  function automatic logic [4:0] win_len(input logic [2:0] mode);
    logic [4:0] w;
    case (mode)
      MODE_W1:  w = 5'd1;
      MODE_W2:  w = 5'd2;
      MODE_W3:  w = 5'd3;
      MODE_W4:  w = 5'd4;
      MODE_W8:  w = 5'd8;
      MODE_W16: w = 5'd16;
      default:  w = 5'd0;
    endcase
    return w;
  endfunction

  function automatic logic mode_ok(input logic [2:0] mode);
    return (mode <= MODE_W16);
  endfunction

endpackage

// File: rtl/movavg_ctrl_stats.sv
// movavg_ctrl_stats -- saturating event counters for the controller.
//   clk, rst_n : clock, async active-low reset
//   acc_evt    : one sample accepted this cycle
//   drop_evt   : one warm-up result discarded this cycle
//   stat_acc   : accepted-sample count, sticks at 0xFFFF
//   stat_drop  : discarded warm-up result count, sticks at 0xFFFF
module movavg_ctrl_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_evt,
  input  logic        drop_evt,
  output logic [15:0] stat_acc,
  output logic [15:0] stat_drop
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_acc  <= 16'h0000;
      stat_drop <= 16'h0000;
    end else begin
      if (acc_evt && (stat_acc != 16'hFFFF))
        stat_acc <= stat_acc + 16'h0001;
      if (drop_evt && (stat_drop != 16'hFFFF))
        stat_drop <= stat_drop + 16'h0001;
    end
  end

endmodule

// File: rtl/movavg_ctrl.sv
// movavg_ctrl -- sequencing controller in front of a moving-average datapath.
// Accepts samples, forwards them to the datapath, drops results produced while
// the datapath window is still filling, and presents the rest on a result stream.
//
// State table:
//   IDLE   | datapath disabled, cfg latches directly
//   WARMUP | window filling, results discarded until warm_cnt reaches 1
//   RUN    | every result forwarded
//   SWITCH | new mode pending, waits for the in-flight result before applying it
//
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   enable                        : run enable (drop to 0 forces IDLE)
//   s_valid/s_ready/s_data        : sample input stream
//   cfg_valid/cfg_ready/cfg_mode/cfg_orm : mode-change request
//   cfg_err                       : one-cycle pulse on a rejected mode
//   avg_enable/avg_refresh/avg_din/avg_mode/avg_orm : datapath controls
//   avg_dout/avg_pulse            : datapath result and its valid pulse
//   m_valid/m_ready/m_data        : result output stream
//   stat_acc/stat_drop            : counters, present only with MOVAVG_CTRL_STATS_EN
//
// Build option: define MOVAVG_CTRL_STATS_EN to add the statistics counters.
module movavg_ctrl #(
  parameter int DATA_W    = movavg_pkg::DATA_W,
  parameter int WARM_INIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_mode,
  input  logic              cfg_orm,
  output logic              cfg_err,
  output logic              avg_enable,
  output logic              avg_refresh,
  output logic [DATA_W-1:0] avg_din,
  output logic [2:0]        avg_mode,
  output logic              avg_orm,
  input  logic [DATA_W-1:0] avg_dout,
  input  logic              avg_pulse,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef MOVAVG_CTRL_STATS_EN
  ,
  output logic [15:0]       stat_acc,
  output logic [15:0]       stat_drop
`endif
);

  import movavg_pkg::*;

  localparam logic [4:0] WARM_RST = 5'(WARM_INIT);

  state_t     state;
  logic [4:0] warm_cnt;
  logic       inflight;
  logic       keep;
  logic [2:0] mode_pend;
  logic       orm_pend;
  // Set by reset: the first warm-up after reset must cover the datapath's
  // full initial fill, so IDLE->WARMUP keeps warm_cnt instead of reloading it.
  logic       first_fill;

  logic s_acc;
  logic cfg_acc;
  logic cfg_good;
  logic cfg_bad;

  assign s_ready = enable & ((state == ST_WARMUP) | (state == ST_RUN)) &
                   ~inflight & (~m_valid | m_ready);
  assign cfg_ready = (state != ST_SWITCH);

  assign s_acc    = s_valid & s_ready;
  assign cfg_acc  = cfg_valid & cfg_ready;
  assign cfg_good = cfg_acc & mode_ok(cfg_mode);
  assign cfg_bad  = cfg_acc & ~mode_ok(cfg_mode);

  assign avg_refresh = s_acc;
  assign avg_din     = s_data;
  assign avg_enable  = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      warm_cnt   <= WARM_RST;
      avg_mode   <= MODE_W1;
      avg_orm    <= 1'b0;
      mode_pend  <= MODE_W1;
      orm_pend   <= 1'b0;
      first_fill <= 1'b1;
      inflight   <= 1'b0;
      keep       <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err  <= cfg_bad;
      inflight <= s_acc;
      if (s_acc)
        keep <= (state == ST_RUN) | (warm_cnt == 5'd1);

      // A result is only taken while still enabled; on disable the in-flight
      // result is abandoned but an already-presented one waits for m_ready.
      if (avg_pulse && inflight && keep && enable) begin
        m_data  <= avg_dout;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      if (!enable) begin
        state <= ST_IDLE;
        if (state == ST_SWITCH) begin
          avg_mode <= mode_pend;
          avg_orm  <= orm_pend;
        end else if (cfg_good) begin
          avg_mode <= cfg_mode;
          avg_orm  <= cfg_orm;
          warm_cnt <= win_len(cfg_mode);
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (cfg_good) begin
              avg_mode <= cfg_mode;
              avg_orm  <= cfg_orm;
              warm_cnt <= win_len(cfg_mode);
            end else if (!first_fill) begin
              warm_cnt <= win_len(avg_mode);
            end
            first_fill <= 1'b0;
            state      <= ST_WARMUP;
          end
          ST_WARMUP: begin
            if (cfg_good) begin
              mode_pend <= cfg_mode;
              orm_pend  <= cfg_orm;
              warm_cnt  <= win_len(cfg_mode);
              state     <= ST_SWITCH;
            end else if (s_acc) begin
              warm_cnt <= warm_cnt - 5'd1;
              if (warm_cnt == 5'd1)
                state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (cfg_good) begin
              mode_pend <= cfg_mode;
              orm_pend  <= cfg_orm;
              warm_cnt  <= win_len(cfg_mode);
              state     <= ST_SWITCH;
            end
          end
          ST_SWITCH: begin
            // A sample accepted together with the cfg still completes under
            // the old mode before the datapath sees the new one.
            if (!inflight) begin
              avg_mode <= mode_pend;
              avg_orm  <= orm_pend;
              state    <= ST_WARMUP;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef MOVAVG_CTRL_STATS_EN
  movavg_ctrl_stats u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_evt   (s_acc),
    .drop_evt  (avg_pulse & inflight & ~keep),
    .stat_acc  (stat_acc),
    .stat_drop (stat_drop)
  );
`endif

endmodule

// File: tb/tb_movavg_ctrl.sv
module tb_movavg_ctrl;

  localparam int WARM_INIT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = 16'h0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_mode = 3'b000;
  logic        cfg_orm = 1'b0;
  logic        cfg_err;
  logic        avg_enable;
  logic        avg_refresh;
  logic [15:0] avg_din;
  logic [2:0]  avg_mode;
  logic        avg_orm;
  logic [15:0] avg_dout;
  logic        avg_pulse;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  movavg_ctrl #(.DATA_W(16), .WARM_INIT(WARM_INIT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_orm(cfg_orm), .cfg_err(cfg_err),
    .avg_enable(avg_enable), .avg_refresh(avg_refresh), .avg_din(avg_din),
    .avg_mode(avg_mode), .avg_orm(avg_orm),
    .avg_dout(avg_dout), .avg_pulse(avg_pulse),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  function automatic int wlen(input logic [2:0] m);
    case (m)
      3'b000: return 1;
      3'b001: return 2;
      3'b010: return 3;
      3'b011: return 4;
      3'b100: return 8;
      3'b101: return 16;
      default: return 0;
    endcase
  endfunction

  // Mean of the last w samples (missing history counts as zero).
  function automatic logic [15:0] avg_of(input int h[$], input int w);
    int sum;
    int idx;
    sum = 0;
    for (int i = 0; i < w; i++) begin
      idx = h.size() - 1 - i;
      if (idx >= 0) sum += h[idx];
    end
    return 16'(sum / w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural datapath: one-cycle latency mean, plus stray pulses carrying
  // junk whenever no real result is due.
  int dp_hist[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_pulse <= 1'b0;
      avg_dout  <= 16'h0;
      dp_hist.delete();
    end else if (avg_refresh) begin
      dp_hist.push_back(int'($signed(avg_din)));
      avg_dout  <= avg_of(dp_hist, wlen(avg_mode));
      avg_pulse <= 1'b1;
    end else begin
      avg_pulse <= ($urandom_range(0, 3) == 0);
      avg_dout  <= 16'($urandom);
    end
  end

  // Reference model + scoreboard.
  logic [15:0] exp_q[$];
  int          ref_hist[$];
  logic [2:0]  ref_mode = 3'b000;
  int          drops_left = WARM_INIT - 1;
  bit          fresh = 1'b1;
  bit          ref_idle = 1'b1;
  bit          pend_v = 1'b0;
  logic [15:0] pend_val = 16'h0;
  bit          err_next = 1'b0;
  bit          prev_acc = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      ref_hist.delete();
      ref_mode   = 3'b000;
      drops_left = WARM_INIT - 1;
      fresh      = 1'b1;
      ref_idle   = 1'b1;
      pend_v     = 1'b0;
      err_next   = 1'b0;
      prev_acc   = 1'b0;
    end else begin
      if (pend_v) begin
        if (enable) exp_q.push_back(pend_val);
        pend_v = 1'b0;
      end
      chk("cfg_err", cfg_err, err_next);
      err_next = 1'b0;
      if (!enable) chk("s_ready_disabled", s_ready, 0);
      if (prev_acc) chk("s_ready_rate", s_ready, 0);
      if (m_valid && !m_ready) chk("s_ready_stall", s_ready, 0);
      if (m_valid && m_ready) begin
        chk("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("m_data", m_data, exp_q.pop_front());
      end
      prev_acc = s_valid && s_ready;
      if (s_valid && s_ready) begin
        ref_hist.push_back(int'($signed(s_data)));
        if (drops_left == 0) begin
          pend_v   = 1'b1;
          pend_val = avg_of(ref_hist, wlen(ref_mode));
        end else begin
          drops_left--;
        end
      end
      if (cfg_valid && cfg_ready) begin
        if (wlen(cfg_mode) == 0) begin
          err_next = 1'b1;
        end else begin
          ref_mode   = cfg_mode;
          drops_left = wlen(cfg_mode) - 1;
        end
      end
      if (enable && ref_idle) begin
        if (!fresh) drops_left = wlen(ref_mode) - 1;
        fresh    = 1'b0;
        ref_idle = 1'b0;
      end
      if (!enable) ref_idle = 1'b1;
    end
  end

  // All directed tasks start and end at posedge+1.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = v;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("send_timeout", n < 100, 1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] m);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_mode  = m;
    cfg_orm   = 1'b0;
    @(negedge clk);
    while (!cfg_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("cfg_timeout", n < 100, 1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  // Called right after send(): result must appear exactly 2 cycles after accept.
  task automatic expect_out(input logic [15:0] v);
    @(negedge clk);
    chk("lat_early", m_valid, 0);
    @(negedge clk);
    chk("lat_valid", m_valid, 1);
    chk("lat_data", m_data, v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    int acc;
    bit hs;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_avg_mode", avg_mode, 0);
    chk("rst_avg_orm", avg_orm, 0);
    chk("rst_avg_enable", avg_enable, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    enable = 1'b1;
    cycles(2);
    chk("warm_avg_enable", avg_enable, 1);

    // initial fill: 15 dropped, 16th forwarded
    for (int i = 0; i < 15; i++) send(16'h0100);
    send(16'h0100);
    expect_out(16'h0100);

    // mode 001 in RUN: one drop then (4+8)/2
    cfg(3'b001);
    send(16'd4);
    send(16'd8);
    expect_out(16'd6);

    // rejected mode
    cfg(3'b110);
    @(negedge clk);
    chk("cfg_err_pulse", cfg_err, 1);
    chk("no_switch", cfg_ready, 1);
    @(negedge clk);
    chk("cfg_err_once", cfg_err, 0);
    chk("mode_kept", avg_mode, 3'b001);
    @(posedge clk);
    #1;
    send(16'd20);
    expect_out(16'd14);

    // output stall
    m_ready = 1'b0;
    send(16'd100);
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("stall_valid", m_valid, 1);
    chk("stall_data", m_data, 16'd60);
    @(posedge clk);
    #1 s_valid = 1'b1;
    s_data = 16'd7;
    repeat (10) begin
      @(negedge clk);
      chk("stall_s_ready", s_ready, 0);
      chk("stall_hold", m_data, 16'd60);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(negedge clk);
    chk("release_s_ready", s_ready, 1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    cycles(4);

    // disable while a result is in flight
    send(16'd50);
    enable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("dis_no_valid", m_valid, 0);
    end
    @(posedge clk);
    #1;
    chk("dis_avg_enable", avg_enable, 0);
    enable = 1'b1;
    cycles(2);
    chk("reen_avg_enable", avg_enable, 1);
    send(16'd30);
    send(16'd40);
    expect_out(16'd35);

    // mode 000, continuous s_valid
    cfg(3'b000);
    cycles(3);
    s_valid = 1'b1;
    s_data  = 16'($urandom);
    acc = 0;
    repeat (40) begin
      @(negedge clk);
      hs = s_valid && s_ready;
      if (hs) acc++;
      @(posedge clk);
      #1;
      if (hs) s_data = 16'($urandom);
    end
    s_valid = 1'b0;
    chk("rate_accepts", acc, 20);
    cycles(4);

    // reset during the in-flight cycle
    send(16'd77);
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rst_mid_no_valid", m_valid, 0);
    end
    chk("rst_mid_data", m_data, 0);
    @(posedge clk);
    #1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s_valid   = ($urandom_range(0, 2) != 0);
      s_data    = 16'($urandom_range(0, 2000) - 1000);
      m_ready   = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 39) == 0);
      cfg_mode  = 3'($urandom_range(0, 7));
      cfg_orm   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      @(posedge clk);
      #1;
    end
    s_valid   = 1'b0;
    cfg_valid = 1'b0;
    enable    = 1'b1;
    m_ready   = 1'b1;
    cycles(30);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_pending", pend_v, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/movavg_ctrl.md
MOVAVG_CTRL -- requirements
Module: movavg_ctrl

Interface
REQ-001 Parameter: DATA_W, 16, sample/result width (signed).
REQ-002 Parameter: WARM_INIT, 16, warm-up sample count after reset, matching the datapath's 16-sample initial fill.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  controller run enable.
REQ-006 s_valid / s_ready / s_data  input/output/input  1/1/DATA_W  sample stream handshake.
REQ-007 cfg_valid / cfg_ready / cfg_mode / cfg_orm  input/output/input/input  1/1/3/1  mode-change request; cfg_orm is output-refresh-mode.
REQ-008 cfg_err  output  1  one-cycle pulse when a rejected mode (110/111) is requested.
REQ-009 avg_enable / avg_refresh / avg_din / avg_mode / avg_orm  output  1/1/DATA_W/3/1  drives the moving-average datapath.
REQ-010 avg_dout / avg_pulse  input  DATA_W/1  datapath result and valid pulse.
REQ-011 m_valid / m_ready / m_data  output/input/output  1/1/DATA_W  result stream handshake.

Function
REQ-012 FSM states: IDLE, WARMUP, RUN, SWITCH.
REQ-013 Transitions: IDLE->WARMUP when enable=1; WARMUP->RUN on the accept with warm_cnt==1; RUN->SWITCH and WARMUP->SWITCH on cfg accept; SWITCH->WARMUP once inflight==0; any state->IDLE when enable=0, with priority over all other transitions.
REQ-014 Window length W(mode): 000->1, 001->2, 010->3, 011->4, 100->8, 101->16.
REQ-015 s_ready = enable & state in {WARMUP,RUN} & !inflight & (!m_valid | m_ready).
REQ-016 Sample accept: avg_refresh = s_valid & s_ready (combinational), avg_din = s_data, and inflight is set for exactly one cycle; maximum rate is one sample per 2 cycles.
REQ-017 keep bit is registered at accept: 1 if state==RUN or warm_cnt==1; warm_cnt decrements on each WARMUP accept.
REQ-018 Capture: when avg_pulse & inflight & keep, m_data<=avg_dout and m_valid<=1 on that edge; m_valid is visible 2 cycles after accept.
REQ-019 avg_pulse with inflight=0 or keep=0 is discarded without any side effect.
REQ-020 m_valid clears on m_valid & m_ready, and m_data is held stable while m_valid & !m_ready.
REQ-021 cfg_ready = state!=SWITCH; cfg accept = cfg_valid & cfg_ready.
REQ-022 Mode 110/111 on cfg accept: cfg_err pulses, mode/orm are unchanged, and the state is unchanged.
REQ-023 Valid cfg in IDLE: latch avg_mode/avg_orm and load warm_cnt=W(new).
REQ-024 Valid cfg in WARMUP/RUN: enter SWITCH, apply the new mode on SWITCH exit, and load warm_cnt=W(new).
REQ-025 IDLE->WARMUP entry reloads warm_cnt=W(current mode).
REQ-026 avg_enable = (state!=IDLE).
REQ-027 On enable=0, any pending m_valid holds until consumed, and an in-flight result is discarded.
REQ-028 cfg accept and s accept in the same cycle: the sample uses the old mode and is counted under the old keep rule.

Reset
REQ-029 On rst_n=0: state=IDLE, warm_cnt=WARM_INIT, avg_mode=000, avg_orm=0, inflight=0, keep=0, m_valid=0, m_data=0, cfg_err=0, and stats counters=0.
REQ-030 Reset mid-transfer discards the in-flight result, and no m_valid is produced after release until a new accept occurs.

Configuration
REQ-031 Macro MOVAVG_CTRL_STATS_EN: when defined, adds outputs stat_acc[15:0] (accepted samples) and stat_drop[15:0] (discarded warm-up results), both saturating at 0xFFFF.
REQ-032 When MOVAVG_CTRL_STATS_EN is undefined, these ports and counters are absent and all other behaviour is identical.

Structure
REQ-033 Package movavg_pkg holds the mode encodings, the state enum, DATA_W, and the W(mode) function.
REQ-034 Sub-module movavg_ctrl_stats holds the saturating counters and is instantiated only under MOVAVG_CTRL_STATS_EN.

Verification
REQ-035 Reset, enable=1, 16 samples 0x0100 -> first 15 results dropped; m_data=0x0100 after the 16th accept, 2 cycles later.
REQ-036 In RUN, cfg_mode=001 with samples 4,8 -> 1 dropped result, then m_data=6.
REQ-037 cfg_mode=110 -> cfg_err one cycle; avg_mode unchanged; stream continues uninterrupted.
REQ-038 m_ready=0 for 10 cycles with m_valid=1 -> s_ready=0 throughout and m_data stable; m_ready=1 -> transfer, and s_ready=1 the same cycle.
REQ-039 enable=0 one cycle after an accept -> no m_valid from that sample; re-enable -> WARMUP with warm_cnt=W(mode).
REQ-040 s_valid held high continuously in RUN, mode=000 -> exactly one accept every 2 cycles and m_data equals each input.
